// File: rtl/recovery_ctrl.sv
// Branch-mispredict recovery sequencer: walks the ROB flushing wrong-path entries,
// restores rename state from the checkpoint, then redirects fetch.
module recovery_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         checkpoint_valid,
    input  logic [4:0]   snap_rob_tag,
    input  logic [127:0] snap_rdy_table,
    input  logic [31:0]  correct_pc,
    input  logic [4:0]   rob_tail,
    input  logic         redirect_ready,
    output logic         flush_valid,
    output logic [4:0]   flush_tag,
    output logic         rdy_restore_valid,
    output logic [127:0] rdy_restore_table,
    output logic         tail_restore_valid,
    output logic [4:0]   tail_restore,
    output logic         ckpt_free_valid,
    output logic [4:0]   ckpt_free_tag,
    output logic         redirect_valid,
    output logic [31:0]  redirect_pc,
    output logic         frontend_stall,
    output logic         overlap_err
);

    typedef enum logic [1:0] {IDLE, WALK, RESTORE, REDIRECT} state_t;

    state_t         state, state_d;
    logic [4:0]     remain, remain_d;
    logic [4:0]     lat_tag, lat_tag_d;
    logic [127:0]   lat_table, lat_table_d;
    logic [31:0]    lat_pc, lat_pc_d;
    logic [4:0]     req_cnt;

    logic           flush_valid_d, rdy_restore_valid_d, tail_restore_valid_d;
    logic           ckpt_free_valid_d, redirect_valid_d, frontend_stall_d, overlap_err_d;
    logic [4:0]     flush_tag_d, tail_restore_d, ckpt_free_tag_d;
    logic [127:0]   rdy_restore_table_d;
    logic [31:0]    redirect_pc_d;

    // Entries younger than the branch; 5-bit wrap makes tail==tag flush 31 entries.
    assign req_cnt = rob_tail - snap_rob_tag - 5'd1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d              = state;
        remain_d             = remain;
        lat_tag_d            = lat_tag;
        lat_table_d          = lat_table;
        lat_pc_d             = lat_pc;
        flush_valid_d        = 1'b0;
        rdy_restore_valid_d  = 1'b0;
        tail_restore_valid_d = 1'b0;
        ckpt_free_valid_d    = 1'b0;
        redirect_valid_d     = 1'b0;
        flush_tag_d          = flush_tag;
        rdy_restore_table_d  = rdy_restore_table;
        tail_restore_d       = tail_restore;
        ckpt_free_tag_d      = ckpt_free_tag;
        redirect_pc_d        = redirect_pc;
        overlap_err_d        = overlap_err | (checkpoint_valid && (state != IDLE));

        unique case (state)
            IDLE: begin
                if (checkpoint_valid) begin
                    lat_tag_d   = snap_rob_tag;
                    lat_table_d = snap_rdy_table;
                    lat_pc_d    = correct_pc;
                    if (req_cnt != 5'd0) begin
                        state_d       = WALK;
                        flush_valid_d = 1'b1;
                        flush_tag_d   = rob_tail - 5'd1;
                        remain_d      = req_cnt - 5'd1;
                    end else begin
                        // Nothing to flush: restore straight from the live snapshot inputs.
                        state_d              = RESTORE;
                        rdy_restore_valid_d  = 1'b1;
                        tail_restore_valid_d = 1'b1;
                        ckpt_free_valid_d    = 1'b1;
                        rdy_restore_table_d  = snap_rdy_table;
                        tail_restore_d       = snap_rob_tag + 5'd1;
                        ckpt_free_tag_d      = snap_rob_tag;
                    end
                end
            end
            WALK: begin
                if (remain != 5'd0) begin
                    flush_valid_d = 1'b1;
                    flush_tag_d   = flush_tag - 5'd1;
                    remain_d      = remain - 5'd1;
                end else begin
                    state_d              = RESTORE;
                    rdy_restore_valid_d  = 1'b1;
                    tail_restore_valid_d = 1'b1;
                    ckpt_free_valid_d    = 1'b1;
                    rdy_restore_table_d  = lat_table;
                    tail_restore_d       = lat_tag + 5'd1;
                    ckpt_free_tag_d      = lat_tag;
                end
            end
            RESTORE: begin
                state_d          = REDIRECT;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = lat_pc;
            end
            REDIRECT: begin
                if (redirect_ready) state_d = IDLE;
                else                redirect_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        frontend_stall_d = (state_d != IDLE);
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            remain             <= '0;
            lat_tag            <= '0;
            // NOTE: the wide snapshot register is reset too, since its value is observable via hold.
            lat_table          <= '0;
            lat_pc             <= '0;
            flush_valid        <= 1'b0;
            flush_tag          <= '0;
            rdy_restore_valid  <= 1'b0;
            rdy_restore_table  <= '0;
            tail_restore_valid <= 1'b0;
            tail_restore       <= '0;
            ckpt_free_valid    <= 1'b0;
            ckpt_free_tag      <= '0;
            redirect_valid     <= 1'b0;
            redirect_pc        <= '0;
            frontend_stall     <= 1'b0;
            overlap_err        <= 1'b0;
        end else begin
            state              <= state_d;
            remain             <= remain_d;
            lat_tag            <= lat_tag_d;
            lat_table          <= lat_table_d;
            lat_pc             <= lat_pc_d;
            flush_valid        <= flush_valid_d;
            flush_tag          <= flush_tag_d;
            rdy_restore_valid  <= rdy_restore_valid_d;
            rdy_restore_table  <= rdy_restore_table_d;
            tail_restore_valid <= tail_restore_valid_d;
            tail_restore       <= tail_restore_d;
            ckpt_free_valid    <= ckpt_free_valid_d;
            ckpt_free_tag      <= ckpt_free_tag_d;
            redirect_valid     <= redirect_valid_d;
            redirect_pc        <= redirect_pc_d;
            frontend_stall     <= frontend_stall_d;
            overlap_err        <= overlap_err_d;
        end
    end

endmodule

// File: doc/recovery_ctrl.md
RECOVERY_CTRL -- requirements
Module: recovery_ctrl

Interface
REQ-001 The module SHALL use one clock and one asynchronous, active-low reset; all listed ports are mandatory.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 checkpoint_valid  input  1  snapshot found for the mispredicted branch; a pulse, combinational from the checkpoint store.
REQ-005 snap_rob_tag  input  5  ROB tag of the mispredicted branch.
REQ-006 snap_rdy_table  input  128  PRF ready-bit snapshot taken at branch rename.
REQ-007 correct_pc  input  32  resolved correct target from the ROB, valid with checkpoint_valid.
REQ-008 rob_tail  input  5  current ROB tail, the next free slot.
REQ-009 redirect_ready  input  1  fetch accepts the redirect.
REQ-010 flush_valid / flush_tag  output  1 / 5  kill one ROB entry per cycle.
REQ-011 rdy_restore_valid / rdy_restore_table  output  1 / 128  restore PRF ready bits.
REQ-012 tail_restore_valid / tail_restore  output  1 / 5  new ROB tail.
REQ-013 ckpt_free_valid / ckpt_free_tag  output  1 / 5  release the consumed checkpoint slot.
REQ-014 redirect_valid / redirect_pc  output  1 / 32  fetch redirect.
REQ-015 frontend_stall  output  1  high whenever state is not IDLE.
REQ-016 overlap_err  output  1  sticky flag for a checkpoint_valid dropped while busy.

Function
REQ-017 The FSM SHALL have the states IDLE, WALK, RESTORE and REDIRECT; all outputs SHALL be registered.
REQ-018 In IDLE, checkpoint_valid sampled at an edge SHALL latch snap_rob_tag, snap_rdy_table, correct_pc and rob_tail.
REQ-019 Flush count SHALL be cnt = (rob_tail - snap_rob_tag - 1) mod 32, using 5-bit wrap arithmetic.
REQ-020 If cnt != 0, the FSM SHALL go to WALK; otherwise it SHALL go to RESTORE.
REQ-021 WALK SHALL assert flush_valid for exactly cnt consecutive cycles.
REQ-022 In WALK, flush_tag SHALL start at rob_tail-1 and decrement mod 32, youngest first; the final flush_tag SHALL be snap_rob_tag+1.
REQ-023 After the final flush, the FSM SHALL move to RESTORE.
REQ-024 RESTORE SHALL last exactly one cycle and SHALL assert rdy_restore_valid, tail_restore_valid and ckpt_free_valid together.
REQ-025 In RESTORE, rdy_restore_table SHALL equal the latched table, tail_restore SHALL equal snap_rob_tag+1 mod 32, and ckpt_free_tag SHALL equal snap_rob_tag.
REQ-026 In REDIRECT, redirect_valid SHALL be high with redirect_pc equal to the latched correct_pc, both held stable until redirect_ready.
REQ-027 On the redirect_valid && redirect_ready edge, the FSM SHALL return to IDLE, and redirect_valid SHALL deassert on the next cycle.
REQ-028 First flush (or RESTORE when cnt=0) SHALL occur in the cycle after checkpoint_valid is sampled.
REQ-029 Total busy time SHALL be cnt + 1 + (REDIRECT wait) cycles.
REQ-030 Outside its owning state, every valid output SHALL be 0 and every data output SHALL hold its last value.
REQ-031 checkpoint_valid seen in WALK, RESTORE or REDIRECT SHALL be ignored without changing latched state, and SHALL set overlap_err.
REQ-032 overlap_err SHALL be cleared only by reset.
REQ-033 checkpoint_valid in the same cycle as the REDIRECT handshake SHALL be ignored and SHALL set overlap_err; a new request is accepted only in IDLE.
REQ-034 If rob_tail == snap_rob_tag, then cnt = 31 and the FSM SHALL flush 31 entries, wrapping through the full ROB.
REQ-035 flush_valid and rdy_restore_valid SHALL never be high in the same cycle.

Reset
REQ-036 When reset is low, the FSM SHALL go to IDLE immediately and asynchronously, including mid-WALK or mid-REDIRECT.
REQ-037 During reset, all outputs, latched registers and overlap_err SHALL be 0.
REQ-038 After reset is released, the first accepted checkpoint_valid SHALL be the one sampled on the first rising edge with reset high.

Verification
REQ-039 Basic walk: tag=5, tail=9, correct_pc=0x100, redirect_ready=1 -> flush_tag 8,7,6 on cycles N+1..N+3; RESTORE at N+4 with tail_restore=6, ckpt_free_tag=5; redirect_valid at N+5 with pc 0x100; IDLE at N+6.
REQ-040 No flush: tag=7, tail=8 -> no flush_valid; RESTORE at N+1 with tail_restore=8; redirect at N+2.
REQ-041 Wrap: tag=30, tail=2 -> flush_tag 1,0,31; tail_restore=31.
REQ-042 Backpressure: redirect_ready low for 3 cycles -> redirect_valid and redirect_pc held and frontend_stall=1 throughout; IDLE one cycle after ready rises.
REQ-043 Overlap: checkpoint_valid with tag=12 during WALK -> flush sequence unchanged and overlap_err=1 thereafter.
REQ-044 Reset mid-operation: reset low during the second WALK cycle -> all outputs 0 in that cycle and IDLE after release.
